// File: rtl/nw_cell_ctrl.sv
// nw_cell_ctrl: Needleman-Wunsch fill sequencer/scorer; define SCORE_SAT_EN to clamp sums instead of wrapping
module nw_cell_ctrl #(
    parameter int N = 5,
    parameter logic signed [8:0] MATCH = 9'sd1,
    parameter logic signed [8:0] MISMATCH = -9'sd1,
    parameter logic signed [8:0] GAP = -9'sd2,
    localparam int BitAddr = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         seq_a,
    input  logic [1:0]         seq_b,
    input  logic               signal,
    input  logic signed [8:0]  diag,
    input  logic signed [8:0]  up,
    input  logic signed [8:0]  left,
    output logic               en_read,
    output logic               en_ins,
    output logic               we,
    output logic [BitAddr:0]   i,
    output logic [BitAddr:0]   j,
    output logic signed [8:0]  max,
    output logic [1:0]         dir,
    output logic               dir_valid,
    output logic               busy,
    output logic               done
);
    typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, NEXT, DONE} state_t;
    localparam logic [BitAddr:0] LAST = (BitAddr + 1)'(N - 1);
    state_t state, nxt;
    logic signed [8:0] diag_q, up_q, left_q, d, u, l, mx;
    logic match_q;
    logic [1:0] dr;
    function automatic logic signed [9:0] ext(input logic signed [8:0] x);
        ext = {x[8], x};
    endfunction
    function automatic logic signed [8:0] fit(input logic signed [9:0] s);
`ifdef SCORE_SAT_EN
        fit = s > 10'sd255 ? 9'sd255 : s < -10'sd256 ? 9'h100 : s[8:0];
`else
        fit = s[8:0];
`endif
    endfunction
    always_comb begin
        d = fit(ext(diag_q) + ext(match_q ? MATCH : MISMATCH));
        u = fit(ext(up_q) + ext(GAP));
        l = fit(ext(left_q) + ext(GAP));
        dr = (d >= u && d >= l) ? 2'b00 : (u >= l) ? 2'b01 : 2'b10;
        mx = dr == 2'b00 ? d : dr == 2'b01 ? u : l;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? READ : IDLE;
            READ:    nxt = signal ? CALC : READ;
            CALC:    nxt = WRITE;
            WRITE:   nxt = NEXT;
            NEXT:    nxt = (i == LAST && j == LAST) ? DONE : READ;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            en_read   <= 1'b0;
            en_ins    <= 1'b0;
            we        <= 1'b0;
            dir_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            i         <= '0;
            j         <= '0;
            max       <= '0;
            dir       <= 2'b00;
            diag_q    <= '0;
            up_q      <= '0;
            left_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            state     <= nxt;
            en_read   <= nxt == READ;
            en_ins    <= nxt == WRITE;
            we        <= nxt == WRITE;
            dir_valid <= nxt == WRITE;
            busy      <= nxt != IDLE;
            done      <= nxt == DONE;
            if (state == READ && signal) begin
                diag_q  <= diag;
                up_q    <= up;
                left_q  <= left;
                match_q <= seq_a == seq_b;
            end
            if (state == CALC) begin
                max <= mx;
                dir <= dr;
            end
            if (state == IDLE) begin
                i <= '0;
                j <= '0;
            end else if (state == NEXT && nxt == READ) begin
                j <= j == LAST ? '0 : j + 1'b1;
                i <= j == LAST ? i + 1'b1 : i;
            end
        end
    end
endmodule
